pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage integer/FP pipeline (IF, ID, EX, MEM, WB).
- Drives the hold (stall) and bubble (flush) controls of the four pipe registers IF/ID, ID/EX, EX/MEM and MEM/WB, plus the IFU PC hold.
- Sequences three events: load-use bubbles, multi-cycle multiplier waits, and control-transfer redirects resolved in MEM.

Parameters:
- MUL_LATENCY, 4, total EX-stage cycles for a multiply; valid range 1..15; 1 means no stall.
- CNT_W, 4, width of the multiply wait counter; must hold MUL_LATENCY-1.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- id_rs1  in  5  source register 1 of the instruction in ID.
- id_rs2  in  5  source register 2 of the instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_to_reg  in  1  EX instruction is a load.
- ex_mul  in  1  EX instruction is a multiply (valid, not a bubble).
- mem_redirect  in  1  taken branch or jump in MEM; the IFU is redirected this cycle.
- pc_hold  out  1  IFU holds the PC and does not fetch.
- if_id_stall  out  1  IF/ID register holds its value.
- id_ex_stall  out  1  ID/EX register holds its value.
- ex_mem_stall  out  1  EX/MEM register holds its value; always 0 in this design, kept for port compatibility.
- mem_wb_stall  out  1  MEM/WB register holds its value; always 0.
- if_id_flush  out  1  IF/ID register loads zeros (NOP).
- id_ex_flush  out  1  ID/EX register loads zeros (bubble).
- ex_mem_flush  out  1  EX/MEM register loads zeros (bubble).
- mul_busy  out  1  multiplier wait is in progress.

Behaviour:
- State: FSM {IDLE, MUL_WAIT} plus down-counter cnt[CNT_W].
- Reset: state=IDLE, cnt=0. While reset is high, every output is 0.
- Outputs are combinational from state and inputs. The pipe registers give flush priority over stall.

Event priority, high to low: mem_redirect > multiply wait > load-use.

1. Redirect (mem_redirect=1):
   - if_id_flush=id_ex_flush=ex_mem_flush=1; all stalls=0; pc_hold=0.
   - If state=MUL_WAIT: abort to IDLE next cycle, cnt cleared. The younger multiply is squashed.
2. Multiply:
   - Define mul_stall = (state=IDLE && ex_mul && MUL_LATENCY>1) || (state=MUL_WAIT && cnt!=0).
   - While mul_stall: pc_hold=if_id_stall=id_ex_stall=1 and ex_mem_flush=1, so MEM receives bubbles and older instructions drain.
   - IDLE→MUL_WAIT when ex_mul && MUL_LATENCY>1 && !mem_redirect; cnt loads MUL_LATENCY-2.
   - In MUL_WAIT: cnt decrements each cycle. When cnt=0, outputs are released; EX/MEM captures the result that edge; next state=IDLE.
   - Stall cycles per multiply = MUL_LATENCY-1 exactly.
   - mul_busy = mul_stall.
   - A second ex_mul in the release cycle is the new EX occupant only after the edge, so back-to-back multiplies each get a full wait.
3. Load-use (only when no redirect and no mul_stall):
   - Condition: ex_mem_to_reg && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
   - Response: pc_hold=if_id_stall=1, id_ex_flush=1 for one cycle.
   - The load advances, so the condition self-clears next cycle.
   - A load-use hazard present during a multiply wait is re-evaluated after release; it is never lost.
4. Register 0 never creates a hazard.
5. Reset asserted mid-MUL_WAIT: IDLE the following cycle, outputs 0 during reset.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- Defined: adds outputs perf_stall_cycles[32] and perf_flush_events[32], both reset to 0.
  - perf_stall_cycles increments each cycle pc_hold=1.
  - perf_flush_events increments each cycle mem_redirect=1.
  - Both wrap from 0xFFFFFFFF to 0.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Load r5 in EX (ex_rd=5, ex_mem_to_reg=1), ID reads rs2=5 → exactly 1 cycle of pc_hold=if_id_stall=id_ex_flush=1, then all 0; repeat with ex_rd=0 → no stall.
- MUL_LATENCY=4, ex_mul pulse held by stall → mul_busy/pc_hold/ex_mem_flush high for 3 cycles, low on 4th; with MUL_LATENCY=1 → no stall.
- mem_redirect in 2nd cycle of multiply wait → that cycle all three flushes=1, stalls=0; next cycle state IDLE, mul_busy=0.
- Load-use hazard present during multiply wait (MUL_LATENCY=3) → 2 mul stall cycles, then 1 load-use bubble cycle.
- reset asserted in MUL_WAIT for 1 cycle → all outputs 0 that cycle, mul_busy=0 after; with PIPE_HAZARD_PERF_EN, counters read 0.
- PIPE_HAZARD_PERF_EN: one multiply (LATENCY=4) + one load-use + two redirects → perf_stall_cycles=4, perf_flush_events=2.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, multiply waits, MEM redirects.
// Optional performance counters are enabled by defining PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int MUL_LATENCY = 4,
    parameter int CNT_W       = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_to_reg,
    input  logic        ex_mul,
    input  logic        mem_redirect,
    output logic        pc_hold,
    output logic        if_id_stall,
    output logic        id_ex_stall,
    output logic        ex_mem_stall,
    output logic        mem_wb_stall,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        mul_busy
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_events
`endif
);

    typedef enum logic {
        IDLE,
        MUL_WAIT
    } state_e;

    localparam bit               MUL_MULTI = (MUL_LATENCY > 1);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'((MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mul_stall;
    logic             load_use;

    // The first stall cycle happens in IDLE as the multiply enters EX; the counter covers the rest.
    assign mul_stall = ((state_q == IDLE) && ex_mul && MUL_MULTI) ||
                       ((state_q == MUL_WAIT) && (cnt_q != '0));

    assign load_use = ex_mem_to_reg && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (mem_redirect) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ex_mul && MUL_MULTI) begin
                        state_d = MUL_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
                MUL_WAIT: begin
                    // ex_mul is ignored here: during the release cycle it still names the old multiply.
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        pc_hold      = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mul_busy     = 1'b0;
        if (!reset) begin
            mul_busy = mul_stall;
            if (mem_redirect) begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (mul_stall) begin
                // Hold IF..EX around the multiplier and feed bubbles into MEM so older work drains.
                pc_hold      = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (load_use) begin
                pc_hold     = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (pc_hold) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (mem_redirect) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flush_events = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Table-driven bench for pipe_hazard_ctrl with three instances (MUL_LATENCY 4, 1 and 3) sharing inputs.
// Define PIPE_HAZARD_PERF_EN to also check the performance counters.
module tb_pipe_hazard_ctrl;

    typedef struct {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       m2r;
        logic       mul;
        logic       redir;
        logic [8:0] exp;
        string      name;
    } vec_t;

    // Output order: pc_hold, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
    // if_id_flush, id_ex_flush, ex_mem_flush, mul_busy
    localparam logic [8:0] Z   = 9'b000000000;
    localparam logic [8:0] LU  = 9'b110000100;
    localparam logic [8:0] MS  = 9'b111000011;
    localparam logic [8:0] RD  = 9'b000001110;
    localparam logic [8:0] RDB = 9'b000001111;

    logic       clock;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_to_reg, ex_mul, mem_redirect;
    logic [8:0] o4, o1, o3;
    int         testsRun;
    int         testsFailed;
    vec_t       tbl[16];
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] ps4, pf4, ps1, pf1, ps3, pf3;
`endif

    pipe_hazard_ctrl #(.MUL_LATENCY(4), .CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_mul(ex_mul), .mem_redirect(mem_redirect),
        .pc_hold(o4[8]), .if_id_stall(o4[7]), .id_ex_stall(o4[6]), .ex_mem_stall(o4[5]),
        .mem_wb_stall(o4[4]), .if_id_flush(o4[3]), .id_ex_flush(o4[2]), .ex_mem_flush(o4[1]),
        .mul_busy(o4[0])
`ifdef PIPE_HAZARD_PERF_EN
        , .perf_stall_cycles(ps4), .perf_flush_events(pf4)
`endif
    );

    pipe_hazard_ctrl #(.MUL_LATENCY(1), .CNT_W(4)) dut1 (
        .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_mul(ex_mul), .mem_redirect(mem_redirect),
        .pc_hold(o1[8]), .if_id_stall(o1[7]), .id_ex_stall(o1[6]), .ex_mem_stall(o1[5]),
        .mem_wb_stall(o1[4]), .if_id_flush(o1[3]), .id_ex_flush(o1[2]), .ex_mem_flush(o1[1]),
        .mul_busy(o1[0])
`ifdef PIPE_HAZARD_PERF_EN
        , .perf_stall_cycles(ps1), .perf_flush_events(pf1)
`endif
    );

    pipe_hazard_ctrl #(.MUL_LATENCY(3), .CNT_W(4)) dut3 (
        .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_mul(ex_mul), .mem_redirect(mem_redirect),
        .pc_hold(o3[8]), .if_id_stall(o3[7]), .id_ex_stall(o3[6]), .ex_mem_stall(o3[5]),
        .mem_wb_stall(o3[4]), .if_id_flush(o3[3]), .id_ex_flush(o3[2]), .ex_mem_flush(o3[1]),
        .mul_busy(o3[0])
`ifdef PIPE_HAZARD_PERF_EN
        , .perf_stall_cycles(ps3), .perf_flush_events(pf3)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input string name, input logic rst,
                                input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2,
                                input logic [4:0] rd, input logic m2r,
                                input logic mul, input logic redir,
                                input logic [8:0] exp);
        vec_t v;
        v.name  = name;
        v.rst   = rst;
        v.rs1   = rs1;
        v.u1    = u1;
        v.rs2   = rs2;
        v.u2    = u2;
        v.rd    = rd;
        v.m2r   = m2r;
        v.mul   = mul;
        v.redir = redir;
        v.exp   = exp;
        return v;
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 time unit later, well before the rising edge.
    task automatic applyStimulus(input vec_t v);
        @(negedge clock);
        reset         = v.rst;
        id_rs1        = v.rs1;
        id_uses_rs1   = v.u1;
        id_rs2        = v.rs2;
        id_uses_rs2   = v.u2;
        ex_rd         = v.rd;
        ex_mem_to_reg = v.m2r;
        ex_mul        = v.mul;
        mem_redirect  = v.redir;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        applyStimulus(mk("init", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, Z));

        //                name             rst   rs1  u1    rs2  u2    rd   m2r   mul   redir  exp
        tbl[0]  = mk("reset",         1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, Z);
        tbl[1]  = mk("lu_rs2",        1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, LU);
        tbl[2]  = mk("lu_clear",      1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, Z);
        tbl[3]  = mk("lu_r0",         1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, Z);
        tbl[4]  = mk("lu_rs1",        1'b0, 5'd7, 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, LU);
        tbl[5]  = mk("lu_unused",     1'b0, 5'd7, 1'b0, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, Z);
        tbl[6]  = mk("mul_c1",        1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, MS);
        tbl[7]  = mk("mul_c2",        1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, MS);
        tbl[8]  = mk("mul_c3",        1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, MS);
        tbl[9]  = mk("mul_release",   1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, Z);
        tbl[10] = mk("mul2_c1",       1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, MS);
        tbl[11] = mk("mul2_redirect", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, RDB);
        tbl[12] = mk("after_abort",   1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, Z);
        tbl[13] = mk("redir_over_lu", 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, RD);
        tbl[14] = mk("redir_over_mul",1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, RDB);
        tbl[15] = mk("no_mul_entry",  1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, Z);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(tbl[i]);
            checkOutput(tbl[i].name, {23'd0, o4}, {23'd0, tbl[i].exp});
        end

        // MUL_LATENCY=1 never stalls, while the latency-4 instance does.
        applyStimulus(mk("rst", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, Z));
        applyStimulus(mk("l1", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, Z));
        checkOutput("lat1_mul_c1", {23'd0, o1}, {23'd0, Z});
        checkOutput("lat4_mul_c1", {23'd0, o4}, {23'd0, MS});
        applyStimulus(mk("l1", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, Z));
        checkOutput("lat1_mul_c2", {23'd0, o1}, {23'd0, Z});

        // MUL_LATENCY=3 with a load-use hazard pending: two multiply stalls, then one bubble.
        applyStimulus(mk("rst", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, Z));
        applyStimulus(mk("m", 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, Z));
        checkOutput("lat3_lu_c1", {23'd0, o3}, {23'd0, MS});
        applyStimulus(mk("m", 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, Z));
        checkOutput("lat3_lu_c2", {23'd0, o3}, {23'd0, MS});
        applyStimulus(mk("m", 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, Z));
        checkOutput("lat3_lu_release", {23'd0, o3}, {23'd0, LU});
        applyStimulus(mk("m", 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, Z));
        checkOutput("lat3_lu_done", {23'd0, o3}, {23'd0, Z});

        // Reset pulse in the middle of a latency-4 wait.
        applyStimulus(mk("rst", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, Z));
        applyStimulus(mk("m", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, Z));
        applyStimulus(mk("m", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, Z));
        checkOutput("rstmid_wait", {23'd0, o4}, {23'd0, MS});
        applyStimulus(mk("m", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, Z));
        checkOutput("rstmid_outputs", {23'd0, o4}, {23'd0, Z});
        applyStimulus(mk("m", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, Z));
        checkOutput("rstmid_after", {23'd0, o4}, {23'd0, Z});
`ifdef PIPE_HAZARD_PERF_EN
        checkOutput("rstmid_perf_stall", ps4, 32'd0);
        checkOutput("rstmid_perf_flush", pf4, 32'd0);

        // One multiply (3 stall cycles) + one load-use (1) + two redirects.
        applyStimulus(mk("rst", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, Z));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mk("p", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, Z));
        end
        applyStimulus(mk("p", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, Z));
        applyStimulus(mk("p", 1'b0, 5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, Z));
        applyStimulus(mk("p", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, Z));
        applyStimulus(mk("p", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, Z));
        applyStimulus(mk("p", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, Z));
        checkOutput("perf_stall_cycles", ps4, 32'd4);
        checkOutput("perf_flush_events", pf4, 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
